// File: rtl/serial_adder.sv
// serial_adder -- digit-serial adder/subtractor.
//
// One DIGIT-bit full-adder slice adds a WIDTH-bit operand pair over
// N = WIDTH/DIGIT cycles.  The carry is held in a flop between digits.
// Subtraction is a + ~b + 1: b is inverted at load and the carry is seeded with 1.
//
// Optional feature (macro SERIAL_ADDER_OVF_EN): adds output ovf, the signed
// overflow of the final digit (carry into MSB ^ carry out of MSB).
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      request an operation (sampled only when busy=0)
//   sub        0: a+b+cin, 1: a-b (cin ignored)
//   a, b       WIDTH-bit operands, sampled with start
//   cin        carry-in for add mode, sampled with start
//   busy       high for exactly N cycles per operation
//   done       one-cycle pulse when sum/cout are updated
//   sum        registered result, holds until the next done
//   cout       carry-out of MSB (sub: 1 = no borrow)
//   ovf        (SERIAL_ADDER_OVF_EN only) signed overflow
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("serial_adder: DIGIT must be >= 1 and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [DIGIT:0]   w_dsum;
  logic [WIDTH-1:0] w_psum_next;

  // One digit slice: low digits of both operand registers plus the held carry.
  assign w_dsum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                + (DIGIT+1)'(r_carry);

  // Partial sum fills from the top; after N digits it is the full result.
  // With a single digit there is nothing to accumulate, so no register exists.
  generate
    if (N > 1) begin : g_psum
      logic [WIDTH-DIGIT-1:0] r_psum;
      assign w_psum_next = {w_dsum[DIGIT-1:0], r_psum};
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                  r_psum <= '0;
        else if (r_state == RUN)  r_psum <= w_psum_next[WIDTH-1:DIGIT];
        else if (start && r_state != RUN) r_psum <= '0;
      end
    end else begin : g_no_psum
      assign w_psum_next = w_dsum[DIGIT-1:0];
    end
  endgenerate

`ifdef SERIAL_ADDER_OVF_EN
  // Carry into the MSB recovered from the MSB's inputs and sum bit.
  logic w_msb_cin;
  assign w_msb_cin = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_dsum[DIGIT-1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (r_state)
        RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_carry <= w_dsum[DIGIT];
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            sum     <= w_psum_next;
            cout    <= w_dsum[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
            ovf     <= w_msb_cin ^ w_dsum[DIGIT];
`endif
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin // IDLE or DONE: DONE never lasts more than one cycle
          done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end else begin
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // WIDTH=8, DIGIT=1
  logic       st8 = 0, sb8 = 0, ci8 = 0;
  logic [7:0] a8 = 0, b8 = 0, sum8;
  logic       busy8, done8, co8;
  // WIDTH=4, DIGIT=1
  logic       st4 = 0, sb4 = 0, ci4 = 0;
  logic [3:0] a4 = 0, b4 = 0, sum4;
  logic       busy4, done4, co4;
  // WIDTH=16, DIGIT=4
  logic        st16 = 0, sb16 = 0, ci16 = 0;
  logic [15:0] a16 = 0, b16 = 0, sum16;
  logic        busy16, done16, co16;
  // WIDTH=4, DIGIT=4 (single digit)
  logic       st1 = 0, sb1 = 0, ci1 = 0;
  logic [3:0] a1 = 0, b1 = 0, sum1;
  logic       busy1, done1, co1;
`ifdef SERIAL_ADDER_OVF_EN
  logic ovf8, ovf4, ovf16, ovf1;
`endif

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .rst(rst), .start(st8), .sub(sb8), .a(a8), .b(b8), .cin(ci8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(co8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );
  serial_adder #(.WIDTH(4), .DIGIT(1)) u_dut4 (
    .clk(clk), .rst(rst), .start(st4), .sub(sb4), .a(a4), .b(b4), .cin(ci4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(co4)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );
  serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(st16), .sub(sb16), .a(a16), .b(b16), .cin(ci16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(co16)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf16)
`endif
  );
  serial_adder #(.WIDTH(4), .DIGIT(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(st1), .sub(sb1), .a(a1), .b(b1), .cin(ci1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(co1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  task automatic edge_();
    @(posedge clk); #1;
  endtask

  // Issue one op on the 8-bit instance; lat = edges after the accept edge until done.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic s, output logic [7:0] rs, output logic rc,
                      output int lat);
    a8 = a; b8 = b; ci8 = c; sb8 = s; st8 = 1;
    edge_();
    st8 = 0;
    lat = 0;
    while (done8 !== 1'b1 && lat < 20) begin
      edge_();
      lat++;
    end
    rs = sum8; rc = co8;
    edge_();
  endtask

  task automatic test_reset();
    #1;
    n_chk++; if ({busy8, done8, co8, sum8} !== 11'd0)
      $display("FAIL reset8 got busy=%b done=%b cout=%b sum=%h want all 0", busy8, done8, co8, sum8);
    else n_pass++;
    n_chk++; if ({busy4, done4, co4, sum4} !== 7'd0)
      $display("FAIL reset4 got busy=%b done=%b cout=%b sum=%h want all 0", busy4, done4, co4, sum4);
    else n_pass++;
`ifdef SERIAL_ADDER_OVF_EN
    n_chk++; if (ovf8 !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf8);
    else n_pass++;
`endif
    @(negedge clk); rst = 0;
    edge_();
  endtask

  task automatic test_add_wrap();
    int bcnt, dcnt;
    logic tim_ok;
    a8 = 8'hFF; b8 = 8'h01; ci8 = 0; sb8 = 0; st8 = 1;
    edge_();
    st8 = 0;
    bcnt = busy8 ? 1 : 0;
    dcnt = 0; tim_ok = 1;
    for (int k = 1; k <= 8; k++) begin
      edge_();
      if (busy8) bcnt++;
      if (done8) dcnt++;
      if (done8 !== (k == 8)) tim_ok = 0;
    end
    n_chk++; if (!tim_ok || dcnt != 1) $display("FAIL wrap_done_timing got %0d done pulses, timing_ok=%b want 1 pulse after edge 8", dcnt, tim_ok);
    else n_pass++;
    n_chk++; if (sum8 !== 8'h00 || co8 !== 1'b1) $display("FAIL wrap_result got %b_%h want 1_00", co8, sum8);
    else n_pass++;
    n_chk++; if (bcnt != 8) $display("FAIL wrap_busy_cycles got %0d want 8", bcnt);
    else n_pass++;
    edge_();
    n_chk++; if (done8 !== 1'b0 || busy8 !== 1'b0) $display("FAIL wrap_done_clear got done=%b busy=%b want 0 0", done8, busy8);
    else n_pass++;
  endtask

  task automatic test_sub();
    logic [7:0] s; logic c; int lat;
    run8(8'h05, 8'h07, 1'b1, 1'b1, s, c, lat);  // cin must be ignored
    n_chk++; if ({c, s} !== 9'h0FE || lat != 8) $display("FAIL sub_5_7 got %b_%h lat %0d want 0_fe lat 8", c, s, lat);
    else n_pass++;
    run8(8'h07, 8'h05, 1'b0, 1'b1, s, c, lat);
    n_chk++; if ({c, s} !== 9'h102 || lat != 8) $display("FAIL sub_7_5 got %b_%h lat %0d want 1_02 lat 8", c, s, lat);
    else n_pass++;
  endtask

  task automatic test_ignore_and_reset();
    int dcnt;
    logic tim_ok;
    a8 = 8'h12; b8 = 8'h34; ci8 = 0; sb8 = 0; st8 = 1;
    edge_();                       // edge 0
    st8 = 0;
    edge_(); edge_();              // edges 1, 2
    a8 = 8'hFF; b8 = 8'hFF; ci8 = 1; sb8 = 1; st8 = 1;
    edge_();                       // edge 3: start must be ignored
    st8 = 0;
    tim_ok = 1;
    for (int k = 4; k <= 8; k++) begin
      edge_();
      if (done8 !== (k == 8)) tim_ok = 0;
    end
    n_chk++; if (!tim_ok || {co8, sum8} !== 9'h046) $display("FAIL ignore_start got %b_%h timing_ok=%b want 0_46 at edge 8", co8, sum8, tim_ok);
    else n_pass++;
    edge_();
    n_chk++; if (busy8 !== 1'b0 || done8 !== 1'b0) $display("FAIL ignore_no_requeue got busy=%b done=%b want 0 0", busy8, done8);
    else n_pass++;
    // Next op, then reset mid-RUN between clock edges.
    a8 = 8'h01; b8 = 8'h01; ci8 = 0; sb8 = 0; st8 = 1;
    edge_();
    st8 = 0;
    edge_(); edge_();
    #2 rst = 1;
    #1;
    n_chk++; if ({busy8, done8, co8, sum8} !== 11'd0) $display("FAIL async_reset got busy=%b done=%b cout=%b sum=%h want all 0", busy8, done8, co8, sum8);
    else n_pass++;
`ifdef SERIAL_ADDER_OVF_EN
    n_chk++; if (ovf8 !== 1'b0) $display("FAIL async_reset_ovf got %b want 0", ovf8);
    else n_pass++;
`endif
    #2 rst = 0;
    dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      edge_();
      if (done8 !== 1'b0 || busy8 !== 1'b0) dcnt++;
    end
    n_chk++; if (dcnt != 0) $display("FAIL reset_discard got %0d active cycles want 0", dcnt);
    else n_pass++;
  endtask

  task automatic set4(input int i);
    int j;
    if (i < 512) begin
      a4 = 4'(i); b4 = 4'(i >> 4); ci4 = i[8]; sb4 = 0;
    end else begin
      j = i - 512;
      a4 = 4'(j); b4 = 4'(j >> 4); ci4 = 0; sb4 = 1;
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] expv;
    logic tim_ok;
    int nfail;
    nfail = 0;
    set4(0); st4 = 1;
    for (int i = 0; i < 768; i++) begin
      edge_();                     // accept edge of op i
      tim_ok = (busy4 === 1'b1 && done4 === 1'b0);
      if (sb4) expv = {1'b0, a4} + {1'b0, ~b4} + 5'd1;
      else     expv = {1'b0, a4} + {1'b0, b4} + {4'd0, ci4};
      if (i < 767) set4(i + 1); else st4 = 0;
      for (int k = 0; k < 3; k++) begin
        edge_();
        if (busy4 !== 1'b1 || done4 !== 1'b0) tim_ok = 0;
      end
      edge_();
      if (done4 !== 1'b1 || busy4 !== 1'b0) tim_ok = 0;
      n_chk++; if ({co4, sum4} !== expv) begin
        nfail++;
        if (nfail < 16) $display("FAIL b2b_result op %0d got %h want %h", i, {co4, sum4}, expv);
      end else n_pass++;
      n_chk++; if (!tim_ok) begin
        nfail++;
        if (nfail < 16) $display("FAIL b2b_timing op %0d busy/done pattern wrong", i);
      end else n_pass++;
    end
    edge_();
    n_chk++; if (busy4 !== 1'b0 || done4 !== 1'b0) $display("FAIL b2b_end got busy=%b done=%b want 0 0", busy4, done4);
    else n_pass++;
  endtask

  task automatic test_digit4();
    int lat;
    a16 = 16'hFFFF; b16 = 16'h0001; ci16 = 1; sb16 = 0; st16 = 1;
    edge_();
    st16 = 0;
    lat = 0;
    while (done16 !== 1'b1 && lat < 20) begin edge_(); lat++; end
    n_chk++; if ({co16, sum16} !== 17'h10001 || lat != 4) $display("FAIL digit4_wrap got %b_%h lat %0d want 1_0001 lat 4", co16, sum16, lat);
    else n_pass++;
    edge_();
    a16 = 16'h1234; b16 = 16'h4321; ci16 = 0; st16 = 1;
    edge_();
    st16 = 0;
    lat = 0;
    while (done16 !== 1'b1 && lat < 20) begin edge_(); lat++; end
    n_chk++; if ({co16, sum16} !== 17'h05555 || lat != 4) $display("FAIL digit4_plain got %b_%h lat %0d want 0_5555 lat 4", co16, sum16, lat);
    else n_pass++;
    edge_();
  endtask

  task automatic test_single_digit();
    a1 = 4'h9; b1 = 4'h8; ci1 = 0; sb1 = 0; st1 = 1;
    edge_();
    st1 = 0;
    edge_();
    n_chk++; if (done1 !== 1'b1 || busy1 !== 1'b0 || {co1, sum1} !== 5'h11) $display("FAIL n1_result got done=%b busy=%b %b_%h want 1 0 1_1", done1, busy1, co1, sum1);
    else n_pass++;
    edge_();
    n_chk++; if (done1 !== 1'b0) $display("FAIL n1_done_clear got %b want 0", done1);
    else n_pass++;
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf();
    logic [7:0] s; logic c; int lat;
    run8(8'h7F, 8'h01, 1'b0, 1'b0, s, c, lat);
    n_chk++; if (ovf8 !== 1'b1 || s !== 8'h80) $display("FAIL ovf_add got ovf=%b sum=%h want 1 80", ovf8, s);
    else n_pass++;
    run8(8'h80, 8'h01, 1'b0, 1'b1, s, c, lat);
    n_chk++; if (ovf8 !== 1'b1 || s !== 8'h7F) $display("FAIL ovf_sub got ovf=%b sum=%h want 1 7f", ovf8, s);
    else n_pass++;
    run8(8'h10, 8'h01, 1'b0, 1'b0, s, c, lat);
    n_chk++; if (ovf8 !== 1'b0 || s !== 8'h11) $display("FAIL ovf_none got ovf=%b sum=%h want 0 11", ovf8, s);
    else n_pass++;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add_wrap();
    test_sub();
    test_digit4();
    test_single_digit();
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    test_back_to_back();
    test_ignore_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
